// File: rtl/sonata_clkgen_if.sv
// Board-side signal bundle of the Sonata clock/reset sequencer.
// The board (master) drives the reset button; the sequencer (slave) returns lock, enable and system reset.
interface sonata_clkgen_if;
  logic nrst_btn_i;
  logic locked_o;
  logic clk_en_o;
  logic rst_sys_no;

  modport master (output nrst_btn_i, input locked_o, clk_en_o, rst_sys_no);
  modport slave  (input nrst_btn_i, output locked_o, clk_en_o, rst_sys_no);
endinterface

// File: rtl/sonata_clkgen.sv
// Clock/reset sequencer: emulated PLL lock timer, phase-accumulator clock enable,
// and a synchronized button reset released only after lock plus a hold time.
module sonata_clkgen #(
  parameter int unsigned            LockCycles    = 64,
  parameter int unsigned            RstHoldCycles = 16,
  parameter int unsigned            PhaseWidth    = 16,
  parameter logic [PhaseWidth-1:0]  FreqRatio     = 16'h8000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sonata_clkgen_if.slave  bus
);

  localparam logic [15:0] LockLimit = 16'(LockCycles);
  localparam logic [15:0] HoldLast  = 16'(RstHoldCycles - 32'd1);

  logic                  r_btn_meta;
  logic                  r_btn_sync;
  logic [15:0]           r_lock_cnt;
  logic [15:0]           w_lock_cnt_nxt;
  logic                  r_locked;
  logic [PhaseWidth-1:0] r_phase;
  logic [PhaseWidth:0]   w_phase_sum;
  logic                  r_clk_en;
  logic [15:0]           r_hold_cnt;
  logic                  r_rst_sys_n;

  // Lock counter saturates; locked is derived from the next count so it rises on the LockCycles-th edge.
  always_comb begin
    if (r_lock_cnt == LockLimit) begin
      w_lock_cnt_nxt = r_lock_cnt;
    end else begin
      w_lock_cnt_nxt = r_lock_cnt + 16'd1;
    end
  end

  always_comb w_phase_sum = {1'b0, r_phase} + {1'b0, FreqRatio};

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
    end else begin
      r_btn_meta <= bus.nrst_btn_i;
      r_btn_sync <= r_btn_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock_cnt <= 16'd0;
      r_locked   <= 1'b0;
    end else begin
      r_lock_cnt <= w_lock_cnt_nxt;
      r_locked   <= (w_lock_cnt_nxt == LockLimit);
    end
  end

  // The carry out of the accumulator is the enable pulse; frozen until lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_phase  <= '0;
      r_clk_en <= 1'b0;
    end else if (!r_locked) begin
      r_phase  <= '0;
      r_clk_en <= 1'b0;
    end else begin
      r_phase  <= w_phase_sum[PhaseWidth-1:0];
      r_clk_en <= w_phase_sum[PhaseWidth];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold_cnt  <= 16'd0;
      r_rst_sys_n <= 1'b0;
    end else if (!r_locked || !r_btn_sync) begin
      r_hold_cnt  <= 16'd0;
      r_rst_sys_n <= 1'b0;
    end else if (!r_rst_sys_n && (r_hold_cnt == HoldLast)) begin
      r_rst_sys_n <= 1'b1;
    end else if (!r_rst_sys_n) begin
      r_hold_cnt  <= r_hold_cnt + 16'd1;
    end else begin
      r_hold_cnt  <= r_hold_cnt;
    end
  end

  assign bus.locked_o   = r_locked;
  assign bus.clk_en_o   = r_clk_en;
  assign bus.rst_sys_no = r_rst_sys_n;

endmodule

// File: tb/tb_sonata_clkgen.sv
// Scoreboard bench for sonata_clkgen: three parameterisations share one stimulus stream,
// an edge-counting model queues expected {locked, clk_en, rst_sys_n} per edge.
module tb_sonata_clkgen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b1;

  always #5 clk = ~clk;

  sonata_clkgen_if if0 ();
  sonata_clkgen_if if1 ();
  sonata_clkgen_if if2 ();
  assign if0.nrst_btn_i = btn;
  assign if1.nrst_btn_i = btn;
  assign if2.nrst_btn_i = btn;

  sonata_clkgen u_dut0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  sonata_clkgen #(.FreqRatio(16'h4000)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  sonata_clkgen #(.LockCycles(1), .RstHoldCycles(1)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [2:0] act, input logic [2:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // Model parameters per instance
  longint m_lock_p [3] = '{64, 64, 1};
  longint m_hold_p [3] = '{16, 16, 1};
  longint m_ratio  [3] = '{32768, 16384, 32768};

  longint m_edges  [3];
  longint m_k      [3];
  longint m_run    [3];
  logic   m_locked [3];
  logic   m_b1 = 1'b0;
  logic   m_b2 = 1'b0;
  logic [2:0] sb_q [$];

  function automatic logic [2:0] act_of(input int i);
    case (i)
      0:       return {if0.locked_o, if0.clk_en_o, if0.rst_sys_no};
      1:       return {if1.locked_o, if1.clk_en_o, if1.rst_sys_no};
      2:       return {if2.locked_o, if2.clk_en_o, if2.rst_sys_no};
      default: return 3'bxxx;
    endcase
  endfunction

  task automatic step(input logic r, input logic b);
    logic lk_pre, bs_pre, en, rs;
    logic [2:0] exp_v;
    rst = r;
    btn = b;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_edges[i] = 0; m_k[i] = 0; m_run[i] = 0; m_locked[i] = 1'b0;
        en = 1'b0; rs = 1'b0;
      end else begin
        lk_pre = m_locked[i];
        bs_pre = m_b2;
        if (m_edges[i] < 100000) m_edges[i]++;
        m_locked[i] = (m_edges[i] >= m_lock_p[i]);
        if (lk_pre) begin
          m_k[i]++;
          en = (((m_k[i] * m_ratio[i]) % 65536) < m_ratio[i]);
        end else begin
          m_k[i] = 0;
          en = 1'b0;
        end
        if (lk_pre && bs_pre) begin
          if (m_run[i] < 100000) m_run[i]++;
        end else begin
          m_run[i] = 0;
        end
        rs = (m_run[i] >= m_hold_p[i]);
      end
      sb_q.push_back({m_locked[i], en, rs});
    end
    if (r) begin
      m_b2 = 1'b0; m_b1 = 1'b0;
    end else begin
      m_b2 = m_b1; m_b1 = b;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 3'd0, 3'd1);
      end else begin
        exp_v = sb_q.pop_front();
        check_val($sformatf("dut%0d_lk_en_rs", i), act_of(i), exp_v);
      end
    end
  endtask

  initial begin
    int en_cnt;
    en_cnt = 0;

    // Nominal bring-up, button pulse at edge 200, glitch at edge 300
    repeat (3) step(1'b1, 1'b1);
    check_val("reset_state", act_of(0), 3'b000);
    for (int e = 1; e <= 1200; e++) begin
      step(1'b0, (e >= 201 && e <= 205) ? 1'b0 : 1'b1);
      if (e == 1)   check_val("d2_lock_e1", 3'(if2.locked_o), 3'd1);
      if (e == 2)   check_val("d2_rs_e2", 3'(if2.rst_sys_no), 3'd0);
      if (e == 3)   check_val("d2_rs_e3", 3'(if2.rst_sys_no), 3'd1);
      if (e == 63)  check_val("lock_e63", 3'(if0.locked_o), 3'd0);
      if (e == 64)  check_val("lock_e64", 3'(if0.locked_o), 3'd1);
      if (e == 65)  check_val("en_e65", 3'(if0.clk_en_o), 3'd0);
      if (e == 66)  check_val("en_e66", 3'(if0.clk_en_o), 3'd1);
      if (e == 79)  check_val("rs_e79", 3'(if0.rst_sys_no), 3'd0);
      if (e == 80)  check_val("rs_e80", 3'(if0.rst_sys_no), 3'd1);
      if (e == 202) check_val("rs_e202", 3'(if0.rst_sys_no), 3'd1);
      if (e == 203) check_val("rs_e203", 3'(if0.rst_sys_no), 3'd0);
      if (e == 222) check_val("rs_e222", 3'(if0.rst_sys_no), 3'd0);
      if (e == 223) check_val("rs_e223", 3'(if0.rst_sys_no), 3'd1);
      if (e >= 101 && e <= 1100 && if1.clk_en_o) en_cnt++;
      if (e == 300) begin
        btn = 1'b0;
        #2;
        btn = 1'b1;
      end
    end
    check_val("en_cnt_1000", 3'((en_cnt >= 249) && (en_cnt <= 251)), 3'd1);

    // Button held low from reset
    repeat (3) step(1'b1, 1'b0);
    for (int e = 1; e <= 300; e++) begin
      step(1'b0, 1'b0);
      if (e == 63)  check_val("btn0_lock_e63", 3'(if0.locked_o), 3'd0);
      if (e == 64)  check_val("btn0_lock_e64", 3'(if0.locked_o), 3'd1);
      if (e == 300) check_val("btn0_rs_end", {2'b00, if0.rst_sys_no | if2.rst_sys_no}, 3'd0);
    end

    // rst_i pulsed mid-operation at edge 150
    repeat (2) step(1'b1, 1'b1);
    for (int e = 1; e <= 149; e++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check_val("midrst_d0", act_of(0), 3'b000);
    check_val("midrst_d2", act_of(2), 3'b000);
    for (int e = 1; e <= 100; e++) begin
      step(1'b0, 1'b1);
      if (e == 63) check_val("relock_e63", 3'(if0.locked_o), 3'd0);
      if (e == 64) check_val("relock_e64", 3'(if0.locked_o), 3'd1);
      if (e == 80) check_val("rerel_e80", 3'(if0.rst_sys_no), 3'd1);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sonata_clkgen.md
Name: sonata_clkgen

Overview:
- Single-clock, synthesizable clock/reset sequencer for the Sonata board top level.
- Emulates PLL lock with a lock timer.
- Derives the system-domain clock enable from the board clock using a phase accumulator; no real clock multiplication.
- Synchronizes the active-low reset button and releases an active-low system reset only after lock plus a hold time.
- Sits between the board pins and ibex_demo_system.

Parameters:
- LockCycles, 64: rising edges after rst_i release before locked_o asserts; legal range 1..65535.
- RstHoldCycles, 16: consecutive cycles of (locked_o && synchronized button high) required before rst_sys_no deasserts; legal range 1..65535.
- PhaseWidth, 16: phase accumulator width in bits.
- FreqRatio, 16'h8000: accumulator increment. Enable rate = FreqRatio / 2^PhaseWidth; must be nonzero.

Ports:
- clk_i  in  1  board clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- nrst_btn_i  in  1  asynchronous active-low reset button; 0 = reset requested.
- locked_o  out  1  emulated PLL lock.
- clk_en_o  out  1  one-cycle system clock-enable pulse.
- rst_sys_no  out  1  active-low system reset, registered.

Behaviour:
- Reset: while rst_i=1 at a rising edge, all of the following clear: sync flops, lock counter, hold counter, phase accumulator. All outputs are 0: locked_o=0, clk_en_o=0, rst_sys_no=0 (system held in reset).
- Button synchronizer: 2-flop chain, reset value 0 → btn_s. btn_s equals nrst_btn_i delayed by 2 edges. No debounce.
- Lock timer:
  - 16-bit counter increments each edge after rst_i low, saturating at LockCycles.
  - locked_o is registered and equals (count == LockCycles).
  - locked_o is first high after the LockCycles-th edge with rst_i=0.
  - Once high, locked_o stays high until rst_i.
- Phase accumulator:
  - Frozen at 0 while locked_o=0.
  - When locked_o=1: {carry, acc} <= acc + FreqRatio on every edge. Sum is PhaseWidth+1 bits; acc wraps modulo 2^PhaseWidth.
  - clk_en_o <= carry (registered), so it is never high before lock.
  - Default FreqRatio 0x8000: clk_en_o is a 0,1,0,1… pattern, with the first pulse on the 2nd edge after lock.
- Hold/release:
  - If !locked_o or !btn_s: hold count <= 0 and rst_sys_no <= 0.
  - Else if rst_sys_no=0 and count == RstHoldCycles-1: rst_sys_no <= 1.
  - Else if rst_sys_no=0: count++.
  - Once high, rst_sys_no stays high while locked_o && btn_s.
- Button press mid-operation:
  - btn_s low drops rst_sys_no on the next edge and clears the hold count.
  - Release restarts a full RstHoldCycles hold.
  - The lock timer and accumulator are unaffected.
- Button held low from reset: locked_o still asserts on schedule; rst_sys_no stays 0.
- Glitch shorter than one clock that is not sampled: no effect.
- rst_i asserted mid-operation: all outputs 0 on the next edge; the full sequence restarts.
- Simultaneous lock assertion and btn_s rise: the hold count starts on the following edge.
- Nominal release latency with button steady high: rst_sys_no rises after edge LockCycles+RstHoldCycles (edge 80 with defaults, counting the first rst_i=0 edge as 1).

Test Plan:
- Defaults, button held 1, rst_i pulsed 3 cycles then 0:
  - locked_o rises after edge 64.
  - rst_sys_no rises after edge 80.
  - clk_en_o is 0 before lock, then alternates 0/1 with exactly 1 pulse per 2 cycles.
- Button driven 0 at edge 200 for 5 cycles:
  - rst_sys_no falls on edge 203 (2 sync flops plus the register).
  - After release it rises again 16 cycles after btn_s returns high.
  - locked_o and clk_en_o cadence are unchanged.
- Button held 0 from reset for 300 cycles:
  - locked_o=1 at edge 64.
  - rst_sys_no=0 throughout.
- rst_i asserted at edge 150 for 1 cycle:
  - All outputs 0 on the next edge.
  - locked_o reasserts 64 edges after rst_i falls.
- FreqRatio=16'h4000:
  - After lock, clk_en_o pulses every 4th cycle.
  - Count = 250 ±1 over 1000 cycles.
- RstHoldCycles=1, LockCycles=1:
  - locked_o after edge 1.
  - rst_sys_no after edge 2, provided btn_s is already 1. With the 2-edge sync delay, btn_s is 1 at edge 3, so rst_sys_no rises after edge 3.
